// File: rtl/knap_enum.sv
// Enumerates all 32 selections of a 5-item knapsack, probes an external feasibility
// checker one candidate per cycle, and streams feasible picks out with running statistics.
module knap_enum #(
  parameter logic [6:0] VAL_A = 7'd4,
  parameter logic [6:0] VAL_B = 7'd8,
  parameter logic [6:0] VAL_C = 7'd1,
  parameter logic [6:0] VAL_D = 7'd20,
  parameter logic [6:0] VAL_E = 7'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] sel_out,
  input  logic       chk_valid,
  output logic       sol_valid,
  input  logic       sol_ready,
  output logic [4:0] sol_sel,
  output logic [6:0] sol_value,
  output logic [5:0] sol_count,
  output logic [4:0] best_sel,
  output logic [6:0] best_value,
  output logic       best_found
);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_EMIT, S_DONE} state_t;

  state_t     state_q;
  logic [4:0] cand_q;
  logic       busy_q;
  logic       done_q;
  logic       sol_valid_q;
  logic [4:0] sol_sel_q;
  logic [6:0] sol_value_q;
  logic [5:0] sol_count_q;
  logic [4:0] best_sel_q;
  logic [6:0] best_value_q;
  logic       best_found_q;
  logic [6:0] sum_d;

  // Total value of a selection; wraps modulo 128 like the 7-bit outputs.
  function automatic logic [6:0] sel_value(input logic [4:0] s);
    logic [6:0] acc;
    acc = '0;
    if (s[0]) acc = acc + VAL_A;
    if (s[1]) acc = acc + VAL_B;
    if (s[2]) acc = acc + VAL_C;
    if (s[3]) acc = acc + VAL_D;
    if (s[4]) acc = acc + VAL_E;
    return acc;
  endfunction

  assign sum_d = sel_value(cand_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cand_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sol_valid_q  <= 1'b0;
      sol_sel_q    <= '0;
      sol_value_q  <= '0;
      sol_count_q  <= '0;
      best_sel_q   <= '0;
      best_value_q <= '0;
      best_found_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sol_count_q  <= '0;
            best_sel_q   <= '0;
            best_value_q <= '0;
            best_found_q <= 1'b0;
            cand_q       <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_PROBE;
          end
        end
        S_PROBE: begin
          if (chk_valid) begin
            sol_sel_q   <= cand_q;
            sol_value_q <= sum_d;
            sol_valid_q <= 1'b1;
            sol_count_q <= sol_count_q + 6'd1;
            // Strict compare: on a tie the earlier (lower-indexed) selection stays best.
            if (!best_found_q || (sum_d > best_value_q)) begin
              best_sel_q   <= cand_q;
              best_value_q <= sum_d;
              best_found_q <= 1'b1;
            end
            state_q <= S_EMIT;
          end else if (cand_q == 5'd31) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cand_q <= cand_q + 5'd1;
          end
        end
        S_EMIT: begin
          if (sol_ready) begin
            sol_valid_q <= 1'b0;
            if (cand_q == 5'd31) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cand_q  <= cand_q + 5'd1;
              state_q <= S_PROBE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sel_out    = cand_q;
  assign sol_valid  = sol_valid_q;
  assign sol_sel    = sol_sel_q;
  assign sol_value  = sol_value_q;
  assign sol_count  = sol_count_q;
  assign best_sel   = best_sel_q;
  assign best_value = best_value_q;
  assign best_found = best_found_q;

endmodule

// File: tb/tb_knap_enum.sv
// Bench for knap_enum: default-valued and all-ones-valued instances, checker stand-ins,
// and a selection-list reference model with randomized feasibility and backpressure.
module tb_knap_enum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        sol_ready;
  int          which;
  int          mode;
  logic [31:0] mask;

  logic       d_start, d_busy, d_done, d_chk, d_sol_valid, d_best_found;
  logic [4:0] d_sel, d_sol_sel, d_best_sel;
  logic [6:0] d_sol_value, d_best_value;
  logic [5:0] d_sol_count;
  logic       t_start, t_busy, t_done, t_chk, t_sol_valid, t_best_found;
  logic [4:0] t_sel, t_sol_sel, t_best_sel;
  logic [6:0] t_sol_value, t_best_value;
  logic [5:0] t_sol_count;

  logic       o_busy, o_done, o_sol_valid, o_best_found;
  logic [4:0] o_sel, o_sol_sel, o_best_sel;
  logic [6:0] o_sol_value, o_best_value;
  logic [5:0] o_sol_count;

  int n_cmp = 0;
  int n_bad = 0;

  assign d_start = start && (which == 0);
  assign t_start = start && (which == 1);

  knap_enum u_dut (
    .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
    .sel_out(d_sel), .chk_valid(d_chk), .sol_valid(d_sol_valid), .sol_ready(sol_ready),
    .sol_sel(d_sol_sel), .sol_value(d_sol_value), .sol_count(d_sol_count),
    .best_sel(d_best_sel), .best_value(d_best_value), .best_found(d_best_found)
  );

  knap_enum #(.VAL_A(7'd1), .VAL_B(7'd1), .VAL_C(7'd1), .VAL_D(7'd1), .VAL_E(7'd1)) u_tie (
    .clk(clk), .rst(rst), .start(t_start), .busy(t_busy), .done(t_done),
    .sel_out(t_sel), .chk_valid(t_chk), .sol_valid(t_sol_valid), .sol_ready(sol_ready),
    .sol_sel(t_sol_sel), .sol_value(t_sol_value), .sol_count(t_sol_count),
    .best_sel(t_best_sel), .best_value(t_best_value), .best_found(t_best_found)
  );

  // Checker stand-ins: 0 real knapsack rule, 1 never, 2 always, 3 sel 1/2 only, 4 random mask.
  function automatic bit feas(input logic [4:0] s, input int m, input logic [31:0] msk);
    int v, w;
    v = 0;
    w = 0;
    if (s[0]) begin v += 4;  w += 5; end
    if (s[1]) begin v += 8;  w += 6; end
    if (s[2]) begin v += 1;  w += 7; end
    if (s[3]) begin v += 20; w += 9; end
    if (s[4]) begin v += 10; w += 8; end
    case (m)
      0:       return (v >= 30) && (w <= 17);
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return (s == 5'd1) || (s == 5'd2);
      default: return msk[s];
    endcase
  endfunction

  always_comb begin
    d_chk = feas(d_sel, mode, mask);
    t_chk = feas(t_sel, mode, mask);
  end

  always_comb begin
    if (which == 0) begin
      o_busy = d_busy; o_done = d_done; o_sel = d_sel; o_sol_valid = d_sol_valid;
      o_sol_sel = d_sol_sel; o_sol_value = d_sol_value; o_sol_count = d_sol_count;
      o_best_sel = d_best_sel; o_best_value = d_best_value; o_best_found = d_best_found;
    end else begin
      o_busy = t_busy; o_done = t_done; o_sel = t_sel; o_sol_valid = t_sol_valid;
      o_sol_sel = t_sol_sel; o_sol_value = t_sol_value; o_sol_count = t_sol_count;
      o_best_sel = t_best_sel; o_best_value = t_best_value; o_best_found = t_best_found;
    end
  end

  function automatic int model_value(input int s);
    int vals[5];
    int acc;
    if (which == 1) vals = '{1, 1, 1, 1, 1};
    else            vals = '{4, 8, 1, 20, 10};
    acc = 0;
    for (int i = 0; i < 5; i++) if (s[i]) acc += vals[i];
    return acc % 128;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},       o_busy, 0);
    check({tag, "_done"},       o_done, 0);
    check({tag, "_sel_out"},    o_sel, 0);
    check({tag, "_sol_valid"},  o_sol_valid, 0);
    check({tag, "_sol_count"},  o_sol_count, 0);
    check({tag, "_best_value"}, o_best_value, 0);
    check({tag, "_best_sel"},   o_best_sel, 0);
    check({tag, "_best_found"}, o_best_found, 0);
  endtask

  // rmode: 0 ready always, 1 stall 5 cycles per solution, 2 random ready.
  task automatic run_test(input int m, input logic [31:0] msk, input int rmode,
                          input int abort_at, input bit extra_start);
    int exp_q[$];
    int best_s, best_v, nsol, exp_sel, vcnt, stalls, cyc, pulses, v;
    bit found, exp_valid;
    mode = m;
    mask = msk;
    exp_q.delete();
    best_s = 0; best_v = 0; found = 0;
    for (int s = 0; s < 32; s++) begin
      if (feas(s[4:0], m, msk)) begin
        exp_q.push_back(s);
        v = model_value(s);
        if (!found || v > best_v) begin best_s = s; best_v = v; found = 1; end
      end
    end
    nsol = exp_q.size();
    exp_sel = 0; exp_valid = 0; vcnt = 0; stalls = 0;
    sol_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      if (o_done) break;
      start = extra_start && (cyc == 5);
      if (abort_at >= 0 && !o_sol_valid && o_sel == abort_at[4:0]) begin
        #2 rst = 1'b1;
        #1 check_zero_outputs("abort");
        @(posedge clk); #1 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          if (o_done) pulses++;
          if (o_busy) pulses++;
        end
        check("abort_no_done_or_busy", pulses, 0);
        return;
      end
      check("busy", o_busy, 1);
      check("sel_out", o_sel, exp_sel);
      check("sol_valid", o_sol_valid, exp_valid);
      if (o_sol_valid) begin
        check("sol_sel", o_sol_sel, exp_sel);
        check("sol_value", o_sol_value, model_value(exp_sel));
        case (rmode)
          0:       sol_ready = 1'b1;
          1:       sol_ready = (vcnt >= 5);
          default: sol_ready = 1'($urandom_range(0, 1));
        endcase
        vcnt++;
        if (sol_ready) begin
          if (exp_q.size() > 0) check("sol_order", o_sol_sel, exp_q.pop_front());
          else check("sol_unexpected", o_sol_sel, 32);
          vcnt = 0;
          exp_valid = 0;
          exp_sel++;
        end else begin
          stalls++;
        end
      end else begin
        sol_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (feas(exp_sel[4:0], m, msk)) exp_valid = 1;
        else exp_sel++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("done_seen", o_done, 1);
    check("done_cycle", cyc, 33 + nsol + stalls);
    check("done_busy_low", o_busy, 0);
    check("all_cands_probed", exp_sel, 32);
    check("all_sols_emitted", exp_q.size(), 0);
    check("sol_count", o_sol_count, nsol);
    check("best_found", o_best_found, found);
    check("best_sel", o_best_sel, best_s);
    check("best_value", o_best_value, best_v);
    if (extra_start) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("done_one_cycle", o_done, 0);
    check("idle_busy", o_busy, 0);
    @(posedge clk); #1;
    check("start_in_done_ignored", o_busy, 0);
    check("count_held", o_sol_count, nsol);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sol_ready = 1'b0; which = 0; mode = 1; mask = '0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    run_test(0, 32'h0, 0, -1, 1'b0);
    run_test(1, 32'h0, 0, -1, 1'b0);
    run_test(2, 32'h0, 0, -1, 1'b0);
    run_test(0, 32'h0, 1, -1, 1'b0);
    run_test(2, 32'h0, 0, 10, 1'b0);
    run_test(0, 32'h0, 0, -1, 1'b1);
    which = 1;
    run_test(3, 32'h0, 0, -1, 1'b0);
    which = 0;
    for (int r = 0; r < 6; r++) run_test(4, $urandom, 2, -1, 1'b0);
    run_test(2, 32'h0, 1, -1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/knap_enum.md
Name: knap_enum

Overview:
- Sequential enumerator that drives the 5-item knapsack feasibility checker.
- It walks every selection vector from 0 to 31 and presents each one to the checker on sel_out.
- It samples the checker's combinational valid result, keeps statistics, and streams each feasible selection downstream over a valid/ready handshake.
- It sits between the top-level controller (start/done) and the result consumer; the checker hangs off sel_out/chk_valid in the same clock domain.

Parameters:
- VAL_A, 4, value of item A (7-bit)
- VAL_B, 8, value of item B (7-bit)
- VAL_C, 1, value of item C (7-bit)
- VAL_D, 20, value of item D (7-bit)
- VAL_E, 10, value of item E (7-bit)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  begin a full enumeration; ignored unless idle
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when enumeration completes
- sel_out  output  5  candidate to checker; bit0=A, bit1=B, bit2=C, bit3=D, bit4=E
- chk_valid  input  1  checker result for the current sel_out, same cycle (combinational)
- sol_valid  output  1  feasible selection available
- sol_ready  input  1  consumer accepts the solution
- sol_sel  output  5  feasible selection vector
- sol_value  output  7  total value of sol_sel, mod 128
- sol_count  output  6  number of feasible selections found this run (0..32)
- best_sel  output  5  feasible selection with highest value
- best_value  output  7  value of best_sel
- best_found  output  1  at least one feasible selection seen this run

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - All outputs are 0, including sel_out=0, busy=0, done=0, sol_valid=0, sol_count=0, best_*=0.
  - Reset mid-run aborts immediately; no done pulse is issued.
- State IDLE:
  - On start=1: clear sol_count, best_sel, best_value and best_found; set cand=0; go to PROBE.
  - busy rises the next cycle.
- State PROBE:
  - sel_out=cand; chk_valid is sampled at the end of that cycle.
  - Value is the sum of VAL_x for each set bit of cand, truncated to 7 bits.
  - If chk_valid=1:
    - load sol_sel=cand and sol_value=sum;
    - sol_count+=1;
    - if best_found=0 or sum>best_value (strictly greater), set best_sel=cand, best_value=sum, best_found=1;
    - go to EMIT.
  - Ties keep the lower-indexed selection.
  - If chk_valid=0: if cand==31 go to DONE, else cand+=1 and stay in PROBE. Throughput is one candidate per cycle.
- State EMIT:
  - sol_valid=1; sol_sel and sol_value are held stable; sel_out holds cand.
  - On sol_ready=1: sol_valid falls the next cycle; if cand==31 go to DONE, else cand+=1 and go to PROBE.
  - Backpressure may last any number of cycles.
  - sol_ready while sol_valid=0 has no effect.
- State DONE:
  - done=1 for one cycle, busy=0 in that cycle; go to IDLE.
  - sol_count and best_* hold until the next accepted start.
- cand is 5 bits. The comparison against 31 prevents wrap; cand never wraps to 0 inside a run.
- start while busy or in DONE is ignored.
- start in the same cycle as rst: rst wins.
- Latency with no feasible selections: start accepted at cycle 0; PROBE occupies cycles 1..32; done is at cycle 33.
- Each feasible selection adds 1 cycle plus any stall cycles.
- sol_count reaches 32 only when every candidate is feasible; it must not overflow.

Test Plan:
- Default parameters, real checker, sol_ready tied 1, start pulse:
  - exactly one solution, sol_sel=5'b11000 (D+E), sol_value=30;
  - sol_count=1, best_sel=24, best_value=30, best_found=1;
  - done at cycle 34.
- Stub chk_valid=0 always:
  - done at cycle 33, sol_valid never asserts, sol_count=0, best_found=0, best_value=0.
- Stub chk_valid=1 always, sol_ready=1:
  - 32 solutions in sel order 0..31;
  - sol_count=32, best_sel=31, best_value=43;
  - done after 64 busy cycles.
- Backpressure with real checker: hold sol_ready=0 for 5 cycles when sol_valid rises.
  - sol_valid, sol_sel=24, sol_value=30 and sel_out stay constant for those cycles.
  - The run resumes at cand=25 after the handshake.
- Tie: all VAL_x=1, stub chk_valid=1 only for sel 1 and 2 → best_sel=1, best_value=1, sol_count=2.
- Assert rst at cand=10 mid-run:
  - all outputs go to 0 asynchronously, no done pulse.
  - A new start re-runs from cand=0 with the same results as a clean run.
  - start pulsed while busy is ignored; the run still completes once.
